// File: rtl/ysyx_22040127_mul_pkg.sv
// Shared definitions for the multiplier issue/control stage: op encodings,
// FSM states, datapath widths, the product-cache key layout and a sign-extend helper.
package ysyx_22040127_mul_pkg;

  localparam int XLEN   = 64;
  localparam int PROD_W = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } mul_state_e;

  typedef struct packed {
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic            xs;
    logic            ys;
  } mul_key_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN - 32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22040127_mul_opprep.sv
// Combinational helpers: turns an RV64M op plus sources into multiplier operands
// and signedness, and picks the rd value out of a 128-bit product.
module ysyx_22040127_mul_opprep
  import ysyx_22040127_mul_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] x,
  output logic [XLEN-1:0] y,
  output logic            xs,
  output logic            ys,
  input  logic [2:0]      sel_op,
  input  logic [XLEN-1:0] prod_hi,
  input  logic [XLEN-1:0] prod_lo,
  output logic [XLEN-1:0] result
);

  // Operand preparation; unknown op codes fall back to plain MUL handling
  always_comb begin
    x  = src1;
    y  = src2;
    xs = 1'b1;
    ys = 1'b1;
    case (op)
      OP_MULHSU: ys = 1'b0;
      OP_MULHU: begin
        xs = 1'b0;
        ys = 1'b0;
      end
      OP_MULW: begin
        x = sext32(src1[31:0]);
        y = sext32(src2[31:0]);
      end
      default: ;
    endcase
  end

  // Result selection: high half for the MULH family, sign-extended word for MULW
  always_comb begin
    result = prod_lo;
    case (sel_op)
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_hi;
      OP_MULW:                      result = sext32(prod_lo[31:0]);
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22040127_mul_ctrl.sv
// Issue/control stage in front of the multi-cycle Booth multiplier. Accepts one
// multiply at a time, reuses the last product when operands repeat, starts the
// multiplier otherwise, and presents the selected rd value with its tag.
module ysyx_22040127_mul_ctrl
  import ysyx_22040127_mul_pkg::*;
#(
  parameter int BUSY_GUARD = 40,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  mul_x,
  output logic [XLEN-1:0]  mul_y,
  output logic             mul_xs,
  output logic             mul_ys,
  output logic             mul_start,
  input  logic [XLEN-1:0]  mul_high,
  input  logic [XLEN-1:0]  mul_low,
  input  logic             mul_done
);

  localparam int GUARD_W = $clog2(BUSY_GUARD + 1);

  mul_state_e          state, state_next;
  logic [GUARD_W-1:0]  guard;
  logic [2:0]          op_q;
  logic                cache_valid;
  mul_key_t            cache_key;
  logic [PROD_W-1:0]   cache_prod;

  logic [XLEN-1:0]     prep_x, prep_y;
  logic                prep_xs, prep_ys;
  mul_key_t            prep_key;
  logic [2:0]          sel_op;
  logic [XLEN-1:0]     sel_hi, sel_lo, sel_result;
  logic                accept, hit;

  // In IDLE the select path serves a cache hit for the incoming op; otherwise it
  // serves the product coming back from the multiplier for the held op.
  assign sel_op = (state == IDLE) ? in_op : op_q;
  assign sel_hi = (state == IDLE) ? cache_prod[PROD_W-1:XLEN] : mul_high;
  assign sel_lo = (state == IDLE) ? cache_prod[XLEN-1:0]      : mul_low;

  ysyx_22040127_mul_opprep u_opprep (
    .op      (in_op),
    .src1    (in_src1),
    .src2    (in_src2),
    .x       (prep_x),
    .y       (prep_y),
    .xs      (prep_xs),
    .ys      (prep_ys),
    .sel_op  (sel_op),
    .prod_hi (sel_hi),
    .prod_lo (sel_lo),
    .result  (sel_result)
  );

  assign prep_key  = {prep_x, prep_y, prep_xs, prep_ys};
  assign in_ready  = (state == IDLE) && (guard == '0) && !flush;
  assign accept    = in_valid && in_ready;
  assign hit       = cache_valid && (prep_key == cache_key);
  assign out_valid = (state == RESP);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic; a flush while waiting keeps us out of IDLE until the multiplier finishes
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = hit ? RESP : WAIT;
      WAIT: begin
        if (flush)         state_next = mul_done ? IDLE : DRAIN;
        else if (mul_done) state_next = RESP;
      end
      RESP:  if (flush || out_ready) state_next = IDLE;
      DRAIN: if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: guard countdown, operand/tag capture, start pulse, product cache and result
  always_ff @(posedge clk) begin
    if (!rst) begin
      guard       <= GUARD_W'(BUSY_GUARD);
      mul_start   <= 1'b0;
      mul_x       <= '0;
      mul_y       <= '0;
      mul_xs      <= 1'b0;
      mul_ys      <= 1'b0;
      op_q        <= OP_MUL;
      out_result  <= '0;
      out_tag     <= '0;
      cache_valid <= 1'b0;
      cache_key   <= '0;
      cache_prod  <= '0;
    end else begin
      if (guard != '0) guard <= guard - GUARD_W'(1);
      mul_start <= accept && !hit;
      if (accept) begin
        op_q    <= in_op;
        out_tag <= in_tag;
        if (hit) begin
          out_result <= sel_result;
        end else begin
          mul_x  <= prep_x;
          mul_y  <= prep_y;
          mul_xs <= prep_xs;
          mul_ys <= prep_ys;
        end
      end
      if (mul_done) begin
        if (state == WAIT && !flush) begin
          cache_valid <= 1'b1;
          cache_key   <= {mul_x, mul_y, mul_xs, mul_ys};
          cache_prod  <= {mul_high, mul_low};
          out_result  <= sel_result;
        end else if (state == WAIT || state == DRAIN) begin
          cache_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_mul_ctrl.sv
// Scoreboard bench for the multiplier control stage, with a behavioural
// multiplier answering mul_start after a random latency.
module tb_ysyx_22040127_mul_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic [63:0] mul_x;
  logic [63:0] mul_y;
  logic        mul_xs;
  logic        mul_ys;
  logic        mul_start;
  logic [63:0] mul_high;
  logic [63:0] mul_low;
  logic        mul_done;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;
  int   starts;
  int   done_count;
  int   epoch;
  bit   ready_random;
  bit   ready_hold;
  logic cap_xs;
  logic cap_ys;

  ysyx_22040127_mul_ctrl #(.BUSY_GUARD(40), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_xs     (mul_xs),
    .mul_ys     (mul_ys),
    .mul_start  (mul_start),
    .mul_high   (mul_high),
    .mul_low    (mul_low),
    .mul_done   (mul_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] ext(input logic [63:0] v, input bit s);
    return s ? {{64{v[63]}}, v} : {64'b0, v};
  endfunction

  // Reference: RV64M semantics straight from the ISA definition
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] p;
    case (op)
      3'd1: begin p = ext(a, 1'b1) * ext(b, 1'b1); return p[127:64]; end
      3'd2: begin p = ext(a, 1'b1) * ext(b, 1'b0); return p[127:64]; end
      3'd3: begin p = ext(a, 1'b0) * ext(b, 1'b0); return p[127:64]; end
      3'd4: begin
        p = {96'b0, a[31:0]} * {96'b0, b[31:0]};
        return {{32{p[31]}}, p[31:0]};
      end
      default: begin p = ext(a, 1'b0) * ext(b, 1'b0); return p[63:0]; end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic fail_timeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] tag, input bit expect_resp);
    int n;
    exp_t e;
    @(posedge clk);
    #1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_tag   = tag;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_timeout("accept");
    end else if (expect_resp) begin
      e.res = ref_result(op, a, b);
      e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_timeout("drain");
  endtask

  task automatic do_reset();
    int cnt;
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    epoch++;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mul_start", 64'(mul_start), 64'd0);
        checkOutput("rst_mul_x", mul_x, 64'd0);
        checkOutput("rst_mul_y", mul_y, 64'd0);
        checkOutput("rst_mul_sign", {62'd0, mul_xs, mul_ys}, 64'd0);
        checkOutput("rst_out_result", out_result, 64'd0);
        checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
      end
      if (in_ready) break;
      cnt++;
    end
    checkOutput("guard_cycles", 64'(cnt), 64'd40);
  endtask

  // Consumer ready: forced low while stalling, random in the soak phase, else always ready
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_hold)        out_ready = 1'b0;
      else if (ready_random) out_ready = ($urandom_range(0, 3) != 0);
      else                   out_ready = 1'b1;
    end
  end

  // Behavioural multiplier: answers each start after a random latency
  initial begin
    logic [63:0]  cx, cy;
    logic [127:0] p;
    int           lat, ep;
    mul_done = 1'b0;
    mul_high = '0;
    mul_low  = '0;
    forever begin
      @(negedge clk);
      if (rst && mul_start) begin
        starts++;
        ep     = epoch;
        cx     = mul_x;
        cy     = mul_y;
        cap_xs = mul_xs;
        cap_ys = mul_ys;
        lat    = $urandom_range(2, 36);
        p      = ext(mul_x, mul_xs) * ext(mul_y, mul_ys);
        @(negedge clk);
        checkOutput("start_pulse_width", 64'(mul_start), 64'd0);
        repeat (lat - 1) @(negedge clk);
        if (ep == epoch) begin
          checkOutput("mul_x_stable", mul_x, cx);
          checkOutput("mul_y_stable", mul_y, cy);
        end
        mul_high = p[127:64];
        mul_low  = p[63:0];
        mul_done = 1'b1;
        done_count++;
        @(negedge clk);
        mul_done = 1'b0;
      end
    end
  end

  // Monitor: every output handshake consumes the oldest expected response
  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_output: got %h expected none", out_result);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("result", out_result, mon_e.res);
          checkOutput("tag", 64'(out_tag), 64'(mon_e.tag));
        end
      end
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          s0, d0, n;
    bit          bad_ready, bad_valid, bad_stable;
    logic [63:0] a, b, r;
    logic [4:0]  t;
    logic [2:0]  op;
    vectors = 0; miscompares = 0; starts = 0; done_count = 0; epoch = 0;
    ready_random = 1'b0; ready_hold = 1'b0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_src1 = '0; in_src2 = '0; in_tag = '0;
    do_reset();

    // MUL 3 x -5
    s0 = starts;
    applyStimulus(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 1'b1);
    wait_drain();
    checkOutput("mul_start_count", 64'(starts - s0), 64'd1);
    checkOutput("mul_signs", {62'd0, cap_xs, cap_ys}, 64'd3);

    // MULHU all-ones squared, then MULH on the same registers must restart
    applyStimulus(3'd3, '1, '1, 5'd2, 1'b1);
    wait_drain();
    s0 = starts;
    applyStimulus(3'd1, '1, '1, 5'd3, 1'b1);
    wait_drain();
    checkOutput("mulh_sign_miss_start", 64'(starts - s0), 64'd1);

    // MULW ignores upper source bits
    applyStimulus(3'd4, 64'hDEAD_BEEF_7FFF_FFFF, 64'd2, 5'd4, 1'b1);
    wait_drain();

    // MULH then MUL on same operands hits the cache
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    applyStimulus(3'd1, a, b, 5'd5, 1'b1);
    wait_drain();
    s0 = starts;
    applyStimulus(3'd0, a, b, 5'd6, 1'b1);
    @(negedge clk);
    checkOutput("hit_out_valid_next", 64'(out_valid), 64'd1);
    wait_drain();
    checkOutput("hit_no_start", 64'(starts - s0), 64'd0);

    // Flush while waiting: drains without output
    d0 = done_count;
    applyStimulus(3'd0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd7, 1'b0);
    @(negedge clk);
    checkOutput("miss_start_after_accept", 64'(mul_start), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bad_ready = 1'b0; bad_valid = 1'b0; n = 0;
    while (done_count == d0 && n < 100) begin
      @(negedge clk);
      if (in_ready)  bad_ready = 1'b1;
      if (out_valid) bad_valid = 1'b1;
      n++;
    end
    if (n >= 100) fail_timeout("drain_done");
    checkOutput("drain_in_ready_low", 64'(bad_ready), 64'd0);
    checkOutput("drain_no_out_valid", 64'(bad_valid), 64'd0);
    applyStimulus(3'd0, 64'd7, 64'd6, 5'd8, 1'b1);
    wait_drain();

    // Stall in RESP for 5 cycles
    ready_hold = 1'b1;
    applyStimulus(3'd2, {$urandom, $urandom}, {$urandom, $urandom}, 5'd9, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_timeout("stall_out_valid");
    r = out_result;
    t = out_tag;
    bad_ready = 1'b0; bad_valid = 1'b0; bad_stable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) bad_ready = 1'b1;
      if (!out_valid) bad_valid = 1'b1;
      if (out_result !== r || out_tag !== t) bad_stable = 1'b1;
    end
    checkOutput("stall_in_ready_low", 64'(bad_ready), 64'd0);
    checkOutput("stall_out_valid_held", 64'(bad_valid), 64'd0);
    checkOutput("stall_stable", 64'(bad_stable), 64'd0);
    ready_hold = 1'b0;
    wait_drain();

    // Randomised soak with frequent operand reuse to exercise the cache
    ready_random = 1'b1;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 3))
          0:       a = '1;
          1:       a = {32'd0, $urandom};
          default: a = {$urandom, $urandom};
        endcase
        b = {$urandom, $urandom};
      end
      applyStimulus(op, a, b, 5'($urandom_range(0, 31)), 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain();
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of a multiply
    ready_random = 1'b0;
    applyStimulus(3'd0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'h1F, 1'b0);
    @(negedge clk);
    do_reset();
    s0 = starts;
    applyStimulus(3'd0, 64'd7, 64'd6, 5'd10, 1'b1);
    wait_drain();
    checkOutput("post_reset_start", 64'(starts - s0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
